// File: rtl/store_snapshot_dumper.sv
// Serializes the store image as snapshot text: one line of '0'/'1' per word,
// bit 0 first, newline-terminated, over a valid/ready byte stream.
module store_snapshot_dumper #(
  parameter int WORDS  = 32,
  parameter int ADDR_W = 5,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] store_addr,
  output logic              store_rd,
  input  logic [WIDTH-1:0]  store_data,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EMIT,
    S_NL,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] word_reg, word_next;
  logic [BIT_W-1:0]  bit_reg, bit_next;
  logic [WIDTH-1:0]  line_reg, line_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      word_reg  <= '0;
      bit_reg   <= '0;
      line_reg  <= '0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      bit_reg   <= bit_next;
      line_reg  <= line_next;
    end
  end

  // Outputs decode from state only, so an asynchronous reset drops them at once.
  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    bit_next   = bit_reg;
    line_next  = line_reg;
    busy       = 1'b0;
    done       = 1'b0;
    store_addr = '0;
    store_rd   = 1'b0;
    out_data   = 8'h00;
    out_valid  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_FETCH;
          word_next  = '0;
        end
      end
      S_FETCH: begin
        busy       = 1'b1;
        store_addr = word_reg;
        store_rd   = 1'b1;
        state_next = S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        line_next  = store_data;
        bit_next   = '0;
        state_next = S_EMIT;
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = line_reg[bit_reg] ? 8'h31 : 8'h30;
        if (out_ready) begin
          if (bit_reg == BIT_W'(WIDTH - 1)) begin
            state_next = S_NL;
          end else begin
            bit_next = bit_reg + BIT_W'(1);
          end
        end
      end
      S_NL: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = 8'h0A;
        if (out_ready) begin
          if (word_reg == ADDR_W'(WORDS - 1)) begin
            state_next = S_DONE;
          end else begin
            word_next  = word_reg + ADDR_W'(1);
            state_next = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_snapshot_dumper.sv
// Table-driven dump scenarios with a byte scoreboard, plus reset-mid-dump and
// line spot checks.
module tb_store_snapshot_dumper;

  localparam int WORDS  = 32;
  localparam int ADDR_W = 5;
  localparam int WIDTH  = 32;
  localparam int NBYTES = WORDS * (WIDTH + 1);

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] store_addr;
  logic              store_rd;
  logic [WIDTH-1:0]  store_data;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready;

  store_snapshot_dumper #(.WORDS(WORDS), .ADDR_W(ADDR_W), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .store_addr (store_addr),
    .store_rd   (store_rd),
    .store_data (store_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Store model: synchronous read, one-cycle latency.
  logic [WIDTH-1:0] mem [WORDS];
  always @(posedge clk) begin
    if (store_rd) store_data <= mem[store_addr];
  end

  typedef struct {
    int fill;      // 0: mem[n]=n  1: mem[0]=0x401D, rest random  2: random  3: mem[3]=all ones, rest random
    int mode;      // 0: ready high  1: random ready  2: random + 10-cycle stalls
    bit mid_start; // pulse start again at byte 100
    bit change3;   // overwrite store[3] while line 3 is emitting
    int exp_bytes;
    int exp_rd;
    int exp_busy;  // -1 when timing depends on backpressure
    int exp_first;
    int exp_done;
  } vec_t;

  vec_t vecs[5];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = 0;
  bit mon_en = 1'b0;
  int byte_cnt, rd_cnt, busy_cnt, done_cnt, first_cyc, done_cyc, hold_cnt;
  bit prev_stall;
  logic [7:0] prev_data;
  logic [7:0] exp_q[$];
  logic [7:0] rx [NBYTES];
  logic [7:0] gold [NBYTES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: drive out_ready for the coming edge, then observe the DUT.
  task automatic tick();
    logic [7:0] e;
    bit target;
    bit rdy;
    @(negedge clk);
    cyc++;
    rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    target = out_valid && (byte_cnt == 0 || byte_cnt == 5 * (WIDTH + 1) + WIDTH);
    if (mode == 2 && target && hold_cnt < 10) begin
      rdy = 1'b0;
      hold_cnt++;
    end else if (!target) begin
      hold_cnt = 0;
    end
    out_ready = rdy;
    if (!mon_en) begin
      byte_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0;
      first_cyc = -1; done_cyc = -1; hold_cnt = 0; prev_stall = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (store_rd) begin
        chk("rd_addr", 32'(store_addr), 32'(rd_cnt));
        rd_cnt++;
      end
      if (done) begin
        chk("busy_at_done", 32'(busy), 32'd0);
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_byte", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("byte", 32'(out_data), 32'(e));
        end
        if (byte_cnt < NBYTES) rx[byte_cnt] = out_data;
        byte_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  endtask

  task automatic restart_monitor();
    mon_en = 1'b0;
    tick();
    mon_en = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_expected();
    for (int w = 0; w < WORDS; w++) begin
      for (int b = 0; b < WIDTH; b++) exp_q.push_back(mem[w][b] ? 8'h31 : 8'h30);
      exp_q.push_back(8'h0A);
    end
  endtask

  task automatic check_line(input string name, input int line, input string s);
    for (int i = 0; i <= WIDTH; i++) begin
      logic [7:0] c;
      c = (i == WIDTH) ? 8'h0A : 8'(s[i]);
      chk(name, 32'(rx[line * (WIDTH + 1) + i]), 32'(c));
    end
  endtask

  initial begin
    int s_cyc;
    bit mid_done, chg_done;
    string str;

    vecs[0] = '{0, 0, 1'b0, 1'b0, NBYTES, WORDS, 1120, 3, 1121};
    vecs[1] = '{1, 0, 1'b1, 1'b0, NBYTES, WORDS, 1120, 3, 1121};
    vecs[2] = '{0, 2, 1'b0, 1'b0, NBYTES, WORDS, -1, -1, -1};
    vecs[3] = '{2, 1, 1'b0, 1'b0, NBYTES, WORDS, -1, -1, -1};
    vecs[4] = '{3, 1, 1'b0, 1'b1, NBYTES, WORDS, -1, -1, -1};

    reset_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int w = 0; w < WORDS; w++) mem[w] = '0;
    tick(); tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(store_addr), 32'd0);
    chk("rst_rd", 32'(store_rd), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    #2 reset_n = 1'b1;
    tick(); tick();

    for (int r = 0; r < 5; r++) begin
      for (int w = 0; w < WORDS; w++) begin
        case (vecs[r].fill)
          0:       mem[w] = 32'(w);
          default: mem[w] = $urandom;
        endcase
      end
      if (vecs[r].fill == 1) mem[0] = 32'h0000_401D;
      if (vecs[r].fill == 3) mem[3] = 32'hFFFF_FFFF;
      mode = vecs[r].mode;
      restart_monitor();
      push_expected();
      start = 1'b1;
      s_cyc = cyc;
      tick();
      start = 1'b0;
      mid_done = 1'b0;
      chg_done = 1'b0;
      for (int k = 0; k < 20000 && done_cnt == 0; k++) begin
        if (vecs[r].mid_start && !mid_done && byte_cnt >= 100) begin
          mid_done = 1'b1;
          start = 1'b1;
          tick();
          start = 1'b0;
        end else begin
          if (vecs[r].change3 && !chg_done && byte_cnt == 3 * (WIDTH + 1) + 5) begin
            chg_done = 1'b1;
            mem[3] = '0;
          end
          tick();
        end
      end
      chk("done_seen", 32'(done_cnt != 0), 32'd1);
      tick(); tick(); tick();
      chk("byte_count", 32'(byte_cnt), 32'(vecs[r].exp_bytes));
      chk("rd_pulses", 32'(rd_cnt), 32'(vecs[r].exp_rd));
      chk("done_pulses", 32'(done_cnt), 32'd1);
      chk("queue_left", 32'(exp_q.size()), 32'd0);
      if (vecs[r].exp_busy >= 0) begin
        chk("busy_cycles", 32'(busy_cnt), 32'(vecs[r].exp_busy));
        chk("first_latency", 32'(first_cyc - s_cyc), 32'(vecs[r].exp_first));
        chk("done_latency", 32'(done_cyc - s_cyc), 32'(vecs[r].exp_done));
      end
      if (r == 0) begin
        str = "10100000000000000000000000000000";
        check_line("line5", 5, str);
        for (int i = 0; i < NBYTES; i++) gold[i] = rx[i];
      end
      if (r == 1) begin
        str = "10111000000000100000000000000000";
        check_line("line0_401d", 0, str);
      end
      if (r == 2) begin
        for (int i = 0; i < NBYTES; i++) chk("stall_vs_gold", 32'(rx[i]), 32'(gold[i]));
      end
      if (r == 4) begin
        str = "11111111111111111111111111111111";
        check_line("line3_latched", 3, str);
      end
      $display("dump %0d: mode=%0d bytes=%0d rd=%0d busy=%0d done=%0d", r, mode, byte_cnt, rd_cnt,
               busy_cnt, done_cnt);
    end

    // Reset in the middle of a line: outputs drop without waiting for a clock.
    mode = 1;
    for (int w = 0; w < WORDS; w++) mem[w] = 32'hA5A5_0F0F;
    restart_monitor();
    push_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && !(out_valid && byte_cnt >= 3); k++) tick();
    chk("mid_emit_reached", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_addr", 32'(store_addr), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    mon_en = 1'b0;
    tick(); tick();
    #2 reset_n = 1'b1;
    mon_en = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 20; k++) tick();
    chk("post_rst_bytes", 32'(byte_cnt), 32'd0);
    chk("post_rst_busy", 32'(busy_cnt), 32'd0);
    chk("post_rst_done", 32'(done_cnt), 32'd0);
    chk("post_rst_rd", 32'(rd_cnt), 32'd0);
    $display("dump reset: bytes=%0d busy=%0d done=%0d", byte_cnt, busy_cnt, done_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
